qar_timer_mc: RTL and testbench
===============================

# qar_timer_mc

Parametrised multi-channel timer peripheral on the QAR word-addressed register bus. A shared prescaled up-counter with programmable TOP drives NUM_CH identical channels. Each channel runs independently in one of four modes: off, compare (with auto-reload), input capture, or edge-aligned PWM. The block raises a single level interrupt from the W1C status bits.

## Interface
- CNT_W, 32: counter, TOP, compare and capture width (8..32).
- NUM_CH, 4: number of channels (1..8).
- PRE_W, 16: prescaler width (1..32).

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bus_write  in  1  write strobe, one cycle per access
- bus_read  in  1  read enable
- addr_word  in  6  word address
- wdata  in  32  write data; bits above the field width are ignored
- rdata  out  32  combinational read data; 0 when !bus_read or unmapped; fields zero-extended
- capture_in  in  NUM_CH  asynchronous capture pins
- pwm_out  out  NUM_CH  registered PWM outputs
- irq  out  1  |(STATUS & IRQ_EN)

## Operation
- Global register map:
  - 0x00 CTRL: b0 EN; b1 ONESHOT; b2 CLR (strobe, reads 0).
  - 0x01 PRESCALE.
  - 0x02 COUNT (R/W).
  - 0x03 TOP; 0 means 2^CNT_W−1.
  - 0x04 STATUS (W1C): b0 WRAP, b[8+i] CH_EVT, b[16+i] CAP_OVR.
  - 0x05 IRQ_EN: same layout as STATUS.
- Channel i registers, base 0x08+4i:
  - +0 CH_CTRL: b[1:0] MODE (0 off, 1 compare, 2 capture, 3 pwm); b2 AUTO_RELOAD; b3 CAP_FALL; b4 PWM_INV.
  - +1 CH_CMP.
  - +2 CH_PERIOD.
  - +3 CH_CAP (read-only).
- Tick:
  - When EN=1, pre_cnt increments each cycle. When pre_cnt==PRESCALE, a tick is issued and pre_cnt returns to 0. PRESCALE=0 gives a tick every cycle.
  - When EN=0, pre_cnt is held at 0 and no ticks are issued.
- On tick:
  - If COUNT==TOP_eff: COUNT←0 and WRAP is set. If ONESHOT=1, EN←0.
  - Otherwise COUNT←COUNT+1.
- Compare mode:
  - On a tick where the pre-update COUNT==CH_CMP, CH_EVT is set. A match at 0 is valid.
  - If AUTO_RELOAD=1 and CH_PERIOD!=0, CH_CMP←(CH_CMP+CH_PERIOD) mod 2^CNT_W.
- Capture mode:
  - capture_in passes through a 2-flop synchronizer, then an edge register. The selected edge (rising, or falling when CAP_FALL=1) triggers a capture.
  - On capture: CH_CAP←current COUNT and CH_EVT is set. If CH_EVT was already 1, CAP_OVR is also set.
  - Capture operates regardless of EN.
- PWM mode:
  - pwm_out[i] is registered as (COUNT<CH_CMP) XOR PWM_INV.
  - CH_CMP=0 gives constant 0 (before inversion). CH_CMP>TOP_eff gives constant 1.
- In modes other than PWM, pwm_out[i]=0.
- Writing MODE does not clear CH_CAP or status bits.

## Timing
- Reset:
  - All registers, pre_cnt, synchronizer and edge flops, pwm_out, and irq are 0.
  - rdata is 0 while bus_read=0.
  - A capture_in held high through reset release is reported as a rising edge 3 cycles later.
- Write latency: register value is visible to reads the cycle after bus_write.
- The tick effect on COUNT is visible the cycle after the tick.
- Capture latency: a pin transition sampled at edge n updates CH_CAP at edge n+3.
- pwm_out lags COUNT by 1 cycle.
- irq is combinational from STATUS/IRQ_EN flops, so it follows them in the same cycle.
- Priority on simultaneous events:
  - Hardware set beats W1C clear in the same cycle.
  - A bus write to COUNT beats both tick increment and CLR.
  - CLR beats tick: COUNT←0 and pre_cnt←0.
  - A bus write to CH_CMP beats auto-reload.
  - A write of CTRL with EN=1 beats the ONESHOT auto-clear.
- Wrap-around: COUNT, CH_CMP and CH_PERIOD sums wrap modulo 2^CNT_W with no carry out.
- An asynchronous reset mid-count aborts everything immediately. There is no pending state.

## Structure
- Shared package qar_timer_pkg holds:
  - register word offsets (CTRL, PRESCALE, COUNT, TOP, STATUS, IRQ_EN, CH_BASE=0x08, CH_STRIDE=4);
  - MODE encodings;
  - STATUS bit-position constants.
- Sub-module qar_timer_channel:
  - one instance per channel via generate;
  - contains CH_CTRL/CMP/PERIOD/CAP, the synchronizer, edge detection, compare/reload and PWM logic;
  - exports evt and cap_ovr pulses and its read mux.
- The top level holds the prescaler, COUNT/TOP, STATUS/IRQ_EN, address decode and the rdata OR-mux.

## Test plan
- **Prescale and wrap:** PRESCALE=2, TOP=4, EN=1 → COUNT steps every 3 cycles 0..4→0; WRAP sets on the 5th tick; irq asserts when IRQ_EN b0=1; W1C 0x1 clears it.
- **Compare auto-reload:** ch0 MODE=1, AUTO_RELOAD=1, CMP=3, PERIOD=5, TOP=0 → CH_EVT sets at COUNT=3, then 8 and 13; CMP reads 8 after the first match.
- **Capture with overrun:** ch1 MODE=2, rising edge on capture_in[1] when COUNT=10 → CH_CAP=10 three cycles later. A second edge before clear → CAP_OVR (b17) sets.
- **PWM:** ch2 MODE=3, TOP=9, CMP=3 → pwm_out[2] is high for 3 of every 10 counts. PWM_INV=1 gives 7/10. CMP=0 gives constant low.
- **Collisions:** W1C of CH_EVT in the cycle the compare matches → bit remains set. Bus write COUNT=100 on a tick cycle → COUNT reads 100.
- **One-shot and async reset:** ONESHOT=1, TOP=3 → EN reads 0 after the wrap and COUNT holds 0. Asserting rst mid-count → all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/qar_timer_pkg.sv
// qar_timer_pkg: shared constants for the QAR multi-channel timer.
//   - global register word offsets and the channel window layout
//   - channel MODE encodings
//   - CTRL and STATUS/IRQ_EN bit positions
package qar_timer_pkg;

  // Global register word offsets
  localparam logic [5:0] REG_CTRL     = 6'h00;
  localparam logic [5:0] REG_PRESCALE = 6'h01;
  localparam logic [5:0] REG_COUNT    = 6'h02;
  localparam logic [5:0] REG_TOP      = 6'h03;
  localparam logic [5:0] REG_STATUS   = 6'h04;
  localparam logic [5:0] REG_IRQ_EN   = 6'h05;

  // Channel register window: CH_BASE + CH_STRIDE*i + offset
  localparam int CH_BASE       = 8;
  localparam int CH_STRIDE     = 4;
  localparam int CH_OFF_CTRL   = 0;
  localparam int CH_OFF_CMP    = 1;
  localparam int CH_OFF_PERIOD = 2;
  localparam int CH_OFF_CAP    = 3;

  // CTRL bits
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_CLR_BIT     = 2;

  // STATUS / IRQ_EN layout
  localparam int ST_WRAP_BIT = 0;
  localparam int ST_EVT_BASE = 8;
  localparam int ST_OVR_BASE = 16;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_CMP = 2'd1,
    MODE_CAP = 2'd2,
    MODE_PWM = 2'd3
  } ch_mode_t;

  // Word address of register 'off' in channel 'ch'
  function automatic logic [5:0] ch_addr(input int ch, input int off);
    return 6'(CH_BASE + CH_STRIDE * ch + off);
  endfunction

endpackage

// File: rtl/qar_timer_mc_if.sv
// qar_timer_mc_if: QAR word-addressed register bus.
//   bus_write : write strobe, one cycle per access
//   bus_read  : read enable
//   addr_word : word address
//   wdata     : write data
//   rdata     : combinational read data (slave output)
interface qar_timer_mc_if;
  logic        bus_write;
  logic        bus_read;
  logic [5:0]  addr_word;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output bus_write,
    output bus_read,
    output addr_word,
    output wdata,
    input  rdata
  );

  modport slave (
    input  bus_write,
    input  bus_read,
    input  addr_word,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/qar_timer_channel.sv
// qar_timer_channel: one timer channel (off / compare / capture / PWM).
//   clk, rst          : clock, asynchronous active-high reset
//   bus_write/bus_read/addr_word/wdata : register bus (channel decodes its own window)
//   count, tick       : shared counter value (pre-update) and prescaled tick
//   capture_in        : asynchronous capture pin
//   evt_pending       : current CH_EVT status bit, used to flag overrun
//   evt, cap_ovr      : single-cycle set pulses for STATUS
//   pwm_out           : registered PWM output
//   rdata             : this channel's contribution to the read OR-mux
module qar_timer_channel
  import qar_timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_write,
  input  logic             bus_read,
  input  logic [5:0]       addr_word,
  input  logic [31:0]      wdata,
  input  logic [CNT_W-1:0] count,
  input  logic             tick,
  input  logic             capture_in,
  input  logic             evt_pending,
  output logic             evt,
  output logic             cap_ovr,
  output logic             pwm_out,
  output logic [31:0]      rdata
);

  localparam logic [5:0] A_CTRL   = ch_addr(CH_IDX, CH_OFF_CTRL);
  localparam logic [5:0] A_CMP    = ch_addr(CH_IDX, CH_OFF_CMP);
  localparam logic [5:0] A_PERIOD = ch_addr(CH_IDX, CH_OFF_PERIOD);
  localparam logic [5:0] A_CAP    = ch_addr(CH_IDX, CH_OFF_CAP);

  ch_mode_t         mode_reg;
  logic             auto_reload_reg;
  logic             cap_fall_reg;
  logic             pwm_inv_reg;
  logic [CNT_W-1:0] cmp_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] cap_reg;
  logic [1:0]       sync_reg;
  logic             dly_reg;
  logic             edge_reg;
  logic             pwm_reg;

  logic sel_ctrl, sel_cmp, sel_period, sel_cap;
  logic wr_ctrl, wr_cmp, wr_period;
  logic synced, edge_det, cmp_hit, cap_hit, reload;
  logic unused_wdata;

  assign sel_ctrl   = (addr_word == A_CTRL);
  assign sel_cmp    = (addr_word == A_CMP);
  assign sel_period = (addr_word == A_PERIOD);
  assign sel_cap    = (addr_word == A_CAP);

  assign wr_ctrl   = bus_write && sel_ctrl;
  assign wr_cmp    = bus_write && sel_cmp;
  assign wr_period = bus_write && sel_period;

  // Upper write-data bits beyond each field are intentionally ignored.
  assign unused_wdata = ^wdata;

  // Second synchronizer stage feeds the edge detector; the detected edge is
  // registered once more so a pin change sampled at edge n lands in CH_CAP
  // at edge n+3.
  assign synced   = sync_reg[1];
  assign edge_det = cap_fall_reg ? (dly_reg & ~synced) : (synced & ~dly_reg);

  assign cmp_hit = (mode_reg == MODE_CMP) && tick && (count == cmp_reg);
  assign cap_hit = (mode_reg == MODE_CAP) && edge_reg;
  assign reload  = cmp_hit && auto_reload_reg && (period_reg != '0);

  assign evt     = cmp_hit | cap_hit;
  assign cap_ovr = cap_hit & evt_pending;
  assign pwm_out = pwm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg        <= MODE_OFF;
      auto_reload_reg <= 1'b0;
      cap_fall_reg    <= 1'b0;
      pwm_inv_reg     <= 1'b0;
      cmp_reg         <= '0;
      period_reg      <= '0;
      cap_reg         <= '0;
      sync_reg        <= '0;
      dly_reg         <= 1'b0;
      edge_reg        <= 1'b0;
      pwm_reg         <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], capture_in};
      dly_reg  <= synced;
      edge_reg <= edge_det;

      if (wr_ctrl) begin
        mode_reg        <= ch_mode_t'(wdata[1:0]);
        auto_reload_reg <= wdata[2];
        cap_fall_reg    <= wdata[3];
        pwm_inv_reg     <= wdata[4];
      end

      // A bus write to CMP wins over the auto-reload step.
      if (wr_cmp) begin
        cmp_reg <= wdata[CNT_W-1:0];
      end else if (reload) begin
        cmp_reg <= cmp_reg + period_reg;
      end

      if (wr_period) begin
        period_reg <= wdata[CNT_W-1:0];
      end

      if (cap_hit) begin
        cap_reg <= count;
      end

      // CMP=0 never satisfies count<cmp; CMP>TOP_eff always does.
      pwm_reg <= (mode_reg == MODE_PWM) && ((count < cmp_reg) ^ pwm_inv_reg);
    end
  end

  always_comb begin
    rdata = '0;
    if (bus_read) begin
      if (sel_ctrl) begin
        rdata = {27'd0, pwm_inv_reg, cap_fall_reg, auto_reload_reg, mode_reg};
      end else if (sel_cmp) begin
        rdata = 32'(cmp_reg);
      end else if (sel_period) begin
        rdata = 32'(period_reg);
      end else if (sel_cap) begin
        rdata = 32'(cap_reg);
      end
    end
  end

endmodule

// File: rtl/qar_timer_mc.sv
// qar_timer_mc: multi-channel timer peripheral on the QAR register bus.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : qar_timer_mc_if slave (bus_write, bus_read, addr_word, wdata, rdata)
//   capture_in : asynchronous capture pins, one per channel
//   pwm_out    : registered PWM outputs, one per channel
//   irq        : |(STATUS & IRQ_EN), combinational from flops
// Holds the prescaler, COUNT/TOP, STATUS/IRQ_EN, global decode and the
// rdata OR-mux; per-channel logic lives in qar_timer_channel.
module qar_timer_mc
  import qar_timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  qar_timer_mc_if.slave     bus,
  input  logic [NUM_CH-1:0] capture_in,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  logic              en_reg;
  logic              oneshot_reg;
  logic [PRE_W-1:0]  prescale_reg;
  logic [PRE_W-1:0]  pre_cnt_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  top_reg;
  logic              wrap_reg;
  logic [NUM_CH-1:0] evt_reg;
  logic [NUM_CH-1:0] ovr_reg;
  logic              irq_wrap_en_reg;
  logic [NUM_CH-1:0] irq_evt_en_reg;
  logic [NUM_CH-1:0] irq_ovr_en_reg;

  logic wr_ctrl, wr_prescale, wr_count, wr_top, wr_status, wr_irq_en;
  logic clr, tick, at_top, ctr_step;
  logic [CNT_W-1:0]  top_eff;
  logic [NUM_CH-1:0] ch_evt, ch_ovr, evt_clr, ovr_clr;
  logic              wrap_clr;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       status_word, irq_en_word, rdata_mux;

  assign wr_ctrl     = bus.bus_write && (bus.addr_word == REG_CTRL);
  assign wr_prescale = bus.bus_write && (bus.addr_word == REG_PRESCALE);
  assign wr_count    = bus.bus_write && (bus.addr_word == REG_COUNT);
  assign wr_top      = bus.bus_write && (bus.addr_word == REG_TOP);
  assign wr_status   = bus.bus_write && (bus.addr_word == REG_STATUS);
  assign wr_irq_en   = bus.bus_write && (bus.addr_word == REG_IRQ_EN);

  assign clr     = wr_ctrl && bus.wdata[CTRL_CLR_BIT];
  assign top_eff = (top_reg == '0) ? '1 : top_reg;
  assign tick    = en_reg && (pre_cnt_reg == prescale_reg);
  assign at_top  = (count_reg == top_eff);
  // Tick as seen by the counter: a COUNT write or CLR overrides it.
  assign ctr_step = tick && !clr && !wr_count;

  assign wrap_clr = wr_status && bus.wdata[ST_WRAP_BIT];
  assign evt_clr  = wr_status ? bus.wdata[ST_EVT_BASE +: NUM_CH] : '0;
  assign ovr_clr  = wr_status ? bus.wdata[ST_OVR_BASE +: NUM_CH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg          <= 1'b0;
      oneshot_reg     <= 1'b0;
      prescale_reg    <= '0;
      pre_cnt_reg     <= '0;
      count_reg       <= '0;
      top_reg         <= '0;
      wrap_reg        <= 1'b0;
      evt_reg         <= '0;
      ovr_reg         <= '0;
      irq_wrap_en_reg <= 1'b0;
      irq_evt_en_reg  <= '0;
      irq_ovr_en_reg  <= '0;
    end else begin
      // A CTRL write (EN=1 or otherwise) wins over the one-shot auto-clear.
      if (wr_ctrl) begin
        en_reg      <= bus.wdata[CTRL_EN_BIT];
        oneshot_reg <= bus.wdata[CTRL_ONESHOT_BIT];
      end else if (ctr_step && at_top && oneshot_reg) begin
        en_reg <= 1'b0;
      end

      if (wr_prescale) prescale_reg <= bus.wdata[PRE_W-1:0];
      if (wr_top)      top_reg      <= bus.wdata[CNT_W-1:0];

      if (!en_reg || clr || tick) begin
        pre_cnt_reg <= '0;
      end else begin
        pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
      end

      if (wr_count) begin
        count_reg <= bus.wdata[CNT_W-1:0];
      end else if (clr) begin
        count_reg <= '0;
      end else if (tick) begin
        count_reg <= at_top ? '0 : count_reg + CNT_W'(1);
      end

      // Hardware set beats the W1C clear.
      wrap_reg <= (wrap_reg & ~wrap_clr) | (ctr_step & at_top);
      evt_reg  <= (evt_reg & ~evt_clr) | ch_evt;
      ovr_reg  <= (ovr_reg & ~ovr_clr) | ch_ovr;

      if (wr_irq_en) begin
        irq_wrap_en_reg <= bus.wdata[ST_WRAP_BIT];
        irq_evt_en_reg  <= bus.wdata[ST_EVT_BASE +: NUM_CH];
        irq_ovr_en_reg  <= bus.wdata[ST_OVR_BASE +: NUM_CH];
      end
    end
  end

  assign irq = (wrap_reg & irq_wrap_en_reg) |
               (|(evt_reg & irq_evt_en_reg)) |
               (|(ovr_reg & irq_ovr_en_reg));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    qar_timer_channel #(
      .CNT_W  (CNT_W),
      .CH_IDX (gi)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .bus_write   (bus.bus_write),
      .bus_read    (bus.bus_read),
      .addr_word   (bus.addr_word),
      .wdata       (bus.wdata),
      .count       (count_reg),
      .tick        (tick),
      .capture_in  (capture_in[gi]),
      .evt_pending (evt_reg[gi]),
      .evt         (ch_evt[gi]),
      .cap_ovr     (ch_ovr[gi]),
      .pwm_out     (pwm_out[gi]),
      .rdata       (ch_rdata[gi])
    );
  end

  always_comb begin
    status_word                           = '0;
    status_word[ST_WRAP_BIT]              = wrap_reg;
    status_word[ST_EVT_BASE +: NUM_CH]    = evt_reg;
    status_word[ST_OVR_BASE +: NUM_CH]    = ovr_reg;
    irq_en_word                           = '0;
    irq_en_word[ST_WRAP_BIT]              = irq_wrap_en_reg;
    irq_en_word[ST_EVT_BASE +: NUM_CH]    = irq_evt_en_reg;
    irq_en_word[ST_OVR_BASE +: NUM_CH]    = irq_ovr_en_reg;
  end

  always_comb begin
    rdata_mux = '0;
    if (bus.bus_read) begin
      case (bus.addr_word)
        REG_CTRL:     rdata_mux = {30'd0, oneshot_reg, en_reg};
        REG_PRESCALE: rdata_mux = 32'(prescale_reg);
        REG_COUNT:    rdata_mux = 32'(count_reg);
        REG_TOP:      rdata_mux = 32'(top_reg);
        REG_STATUS:   rdata_mux = status_word;
        REG_IRQ_EN:   rdata_mux = irq_en_word;
        default:      rdata_mux = '0;
      endcase
    end
    // Channels drive zero unless their own window is being read.
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_mux = rdata_mux | ch_rdata[i];
    end
  end

  assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_qar_timer_mc.sv
// tb_qar_timer_mc: directed self-checking bench for qar_timer_mc.
// Inputs are driven just after the falling edge, outputs sampled in the low
// phase; every comparison goes through check_val.
module tb_qar_timer_mc;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_PRE    = 6'h01;
  localparam logic [5:0] A_COUNT  = 6'h02;
  localparam logic [5:0] A_TOP    = 6'h03;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_IRQEN  = 6'h05;
  localparam logic [5:0] A_UNMAP  = 6'h07;
  localparam logic [5:0] CH0_CTRL = 6'h08;
  localparam logic [5:0] CH0_CMP  = 6'h09;
  localparam logic [5:0] CH0_PER  = 6'h0A;
  localparam logic [5:0] CH1_CTRL = 6'h0C;
  localparam logic [5:0] CH1_CAP  = 6'h0F;
  localparam logic [5:0] CH2_CTRL = 6'h10;
  localparam logic [5:0] CH2_CMP  = 6'h11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] capture_in = '0;
  logic [3:0] pwm_out;
  logic       irq;
  int         checks = 0;
  int         failures = 0;
  int         hi;

  qar_timer_mc_if bus_if ();

  qar_timer_mc #(
    .CNT_W  (32),
    .NUM_CH (4),
    .PRE_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .capture_in (capture_in),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write; call just after a falling edge, returns at the next one.
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    bus_if.bus_write = 1'b1;
    bus_if.addr_word = a;
    bus_if.wdata     = d;
    @(negedge clk);
    bus_if.bus_write = 1'b0;
    bus_if.wdata     = '0;
    $display("WR   addr=0x%02h data=0x%08h", a, d);
  endtask

  // Combinational read inside the low phase; no clock edge consumed.
  task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_if.bus_read  = 1'b1;
    bus_if.addr_word = a;
    #1;
    d = bus_if.rdata;
    bus_if.bus_read = 1'b0;
    check_val(tag, d, exp);
  endtask

  task automatic pwm_count(output int n_hi);
    n_hi = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pwm_out[2]) n_hi++;
    end
  endtask

  initial begin
    bus_if.bus_write = 1'b0;
    bus_if.bus_read  = 1'b0;
    bus_if.addr_word = '0;
    bus_if.wdata     = '0;

    // ---------------- reset state ----------------
    step(2);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_pwm", 32'(pwm_out), 32'd0);
    rst = 1'b0;
    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_count", A_COUNT, 32'd0);
    rd_check("rst_status", A_STATUS, 32'd0);
    rd_check("rst_ch0_cmp", CH0_CMP, 32'd0);

    // ---------------- prescale and wrap ----------------
    bus_wr(A_TOP, 32'd4);
    bus_wr(A_PRE, 32'd2);
    bus_wr(A_IRQEN, 32'd1);
    rd_check("top_rb", A_TOP, 32'd4);
    rd_check("unmapped", A_UNMAP, 32'd0);
    bus_wr(A_CTRL, 32'd1);
    step(2);
    rd_check("ps_cnt_n2", A_COUNT, 32'd0);
    step(1);
    rd_check("ps_cnt_n3", A_COUNT, 32'd1);
    step(9);
    rd_check("ps_cnt_n12", A_COUNT, 32'd4);
    rd_check("ps_nowrap", A_STATUS, 32'd0);
    check_val("ps_irq_lo", 32'(irq), 32'd0);
    step(3);
    rd_check("ps_cnt_wrap", A_COUNT, 32'd0);
    rd_check("ps_wrap_set", A_STATUS, 32'd1);
    check_val("ps_irq_hi", 32'(irq), 32'd1);
    bus_wr(A_STATUS, 32'd1);
    rd_check("ps_w1c", A_STATUS, 32'd0);
    check_val("ps_irq_clr", 32'(irq), 32'd0);
    bus_wr(A_CTRL, 32'd4);
    rd_check("clr_count", A_COUNT, 32'd0);
    rd_check("clr_reads0", A_CTRL, 32'd0);

    // ---------------- compare auto-reload ----------------
    bus_wr(A_TOP, 32'd0);
    bus_wr(A_PRE, 32'd0);
    bus_wr(CH0_CTRL, 32'd5);
    bus_wr(CH0_CMP, 32'd3);
    bus_wr(CH0_PER, 32'd5);
    rd_check("ch0_ctrl_rb", CH0_CTRL, 32'd5);
    bus_wr(A_CTRL, 32'd1);
    step(3);
    rd_check("cmp_cnt3", A_COUNT, 32'd3);
    rd_check("cmp_pre3", A_STATUS, 32'd0);
    bus_if.addr_word = A_COUNT;
    #1;
    check_val("rdata_no_read", bus_if.rdata, 32'd0);
    step(1);
    rd_check("cmp_hit3", A_STATUS, 32'h100);
    rd_check("cmp_reload8", CH0_CMP, 32'd8);
    bus_wr(A_STATUS, 32'h100);
    rd_check("cmp_w1c", A_STATUS, 32'd0);
    step(3);
    rd_check("cmp_pre8", A_STATUS, 32'd0);
    step(1);
    rd_check("cmp_hit8", A_STATUS, 32'h100);
    rd_check("cmp_reload13", CH0_CMP, 32'd13);
    bus_wr(A_STATUS, 32'h100);
    step(3);
    rd_check("cmp_pre13", A_STATUS, 32'd0);
    // W1C lands on the same edge as the count==13 match: set wins.
    bus_wr(A_STATUS, 32'h100);
    rd_check("coll_w1c_vs_set", A_STATUS, 32'h100);
    rd_check("cmp_reload18", CH0_CMP, 32'd18);
    // COUNT write on a tick cycle (tick every cycle here).
    bus_wr(A_COUNT, 32'd100);
    rd_check("coll_cnt_wr", A_COUNT, 32'd100);
    bus_wr(A_CTRL, 32'd4);
    bus_wr(CH0_CTRL, 32'd0);
    bus_wr(A_STATUS, 32'hFFFF_FFFF);

    // ---------------- capture with overrun ----------------
    bus_wr(A_COUNT, 32'd10);
    bus_wr(CH1_CTRL, 32'd2);
    capture_in[1] = 1'b1;
    step(3);
    rd_check("cap_early", CH1_CAP, 32'd0);
    step(1);
    rd_check("cap_val10", CH1_CAP, 32'd10);
    rd_check("cap_evt", A_STATUS, 32'h200);
    bus_wr(A_COUNT, 32'd20);
    capture_in[1] = 1'b0;
    step(2);
    capture_in[1] = 1'b1;
    step(3);
    rd_check("cap_hold10", CH1_CAP, 32'd10);
    step(1);
    rd_check("cap_val20", CH1_CAP, 32'd20);
    rd_check("cap_ovr", A_STATUS, 32'h0002_0200);
    bus_wr(A_STATUS, 32'hFFFF_FFFF);
    rd_check("cap_w1c", A_STATUS, 32'd0);
    bus_wr(CH1_CTRL, 32'd0);
    rd_check("cap_kept", CH1_CAP, 32'd20);
    capture_in[1] = 1'b0;

    // ---------------- PWM ----------------
    bus_wr(A_TOP, 32'd9);
    bus_wr(A_CTRL, 32'd4);
    bus_wr(CH2_CTRL, 32'd3);
    bus_wr(CH2_CMP, 32'd3);
    bus_wr(A_CTRL, 32'd1);
    pwm_count(hi);
    check_val("pwm_3of10", 32'(hi), 32'd3);
    bus_wr(CH2_CTRL, 32'd19);
    step(1);
    pwm_count(hi);
    check_val("pwm_inv_7of10", 32'(hi), 32'd7);
    bus_wr(CH2_CTRL, 32'd3);
    bus_wr(CH2_CMP, 32'd0);
    step(1);
    pwm_count(hi);
    check_val("pwm_cmp0", 32'(hi), 32'd0);
    bus_wr(CH2_CMP, 32'd12);
    step(1);
    pwm_count(hi);
    check_val("pwm_cmp_gt_top", 32'(hi), 32'd10);
    bus_wr(A_CTRL, 32'd4);
    bus_wr(CH2_CTRL, 32'd0);
    step(1);
    check_val("pwm_off_low", 32'(pwm_out), 32'd0);

    // ---------------- one-shot ----------------
    bus_wr(A_STATUS, 32'hFFFF_FFFF);
    bus_wr(A_TOP, 32'd3);
    bus_wr(A_CTRL, 32'd3);
    step(3);
    rd_check("os_cnt3", A_COUNT, 32'd3);
    rd_check("os_ctrl_run", A_CTRL, 32'd3);
    step(1);
    rd_check("os_ctrl_stop", A_CTRL, 32'd2);
    rd_check("os_cnt0", A_COUNT, 32'd0);
    check_val("os_irq", 32'(irq), 32'd1);
    step(3);
    rd_check("os_cnt_hold", A_COUNT, 32'd0);

    // ---------------- asynchronous reset mid-count ----------------
    bus_wr(CH2_CTRL, 32'd3);
    bus_wr(CH2_CMP, 32'd12);
    bus_wr(A_CTRL, 32'd1);
    step(2);
    check_val("pre_rst_pwm", 32'(pwm_out), 32'h4);
    check_val("pre_rst_irq", 32'(irq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_pwm", 32'(pwm_out), 32'd0);
    check_val("arst_irq", 32'(irq), 32'd0);
    rd_check("arst_count", A_COUNT, 32'd0);
    rd_check("arst_ctrl", A_CTRL, 32'd0);
    rd_check("arst_ch2", CH2_CTRL, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
